// File: rtl/alu_pipe_unit.sv
// alu_pipe_unit: integer execute unit made of a single-cycle ALU followed by a
// LATENCY-deep result pipeline. Every in-flight op carries a branch mask so it
// can be squashed by a mispredict, and a global kill flushes everything.
// Each stage is exposed on a bypass port. Output backpressure (resp_ready)
// freezes the whole pipe as one unit; bubbles are never collapsed.
//
// Optional build macro: ALU_PIPE_PERF_EN adds the perf_done, perf_killed and
// perf_stall counters. Without it those ports do not exist.

module alu_pipe_unit #(
    parameter int XLEN    = 64,
    parameter int BR_W    = 20,
    parameter int TAG_W   = 7,
    parameter int LATENCY = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_fn,
    input  logic                     req_dw,
    input  logic [XLEN-1:0]          req_in1,
    input  logic [XLEN-1:0]          req_in2,
    input  logic [TAG_W-1:0]         req_pdst,
    input  logic [TAG_W-1:0]         req_rob_idx,
    input  logic [BR_W-1:0]          req_br_mask,
    input  logic                     kill,
    input  logic [BR_W-1:0]          br_resolve_mask,
    input  logic [BR_W-1:0]          br_mispredict_mask,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [XLEN-1:0]          resp_data,
    output logic [TAG_W-1:0]         resp_pdst,
    output logic [TAG_W-1:0]         resp_rob_idx,
    output logic [LATENCY-1:0]       bypass_valid,
    output logic [LATENCY*TAG_W-1:0] bypass_pdst,
    output logic [LATENCY*XLEN-1:0]  bypass_data
`ifdef ALU_PIPE_PERF_EN
    ,
    output logic [31:0]              perf_done,
    output logic [31:0]              perf_killed,
    output logic [31:0]              perf_stall
`endif
);

    localparam int SHW = $clog2(XLEN);

    // ALU operand preparation and result
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [XLEN-1:0] op_a_zx;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_raw;
    logic [XLEN-1:0] alu_out;

    // Pipeline stage registers, index k = stage k
    logic [LATENCY:1] stg_valid;
    logic [BR_W-1:0]  stg_mask [1:LATENCY];
    logic [XLEN-1:0]  stg_data [1:LATENCY];
    logic [TAG_W-1:0] stg_pdst [1:LATENCY];
    logic [TAG_W-1:0] stg_rob  [1:LATENCY];

    // Stage valid after this cycle's kill / mispredict squash
    logic [LATENCY:1] stg_live;
    logic             req_hit;
    logic             req_fire;
    logic             stall;

    // ALU: 32-bit ops work on sign-extended low words (SRL needs the zero-extended
    // word so ones are not shifted in), then the result is re-extended from bit 31.
    always_comb begin
        op_a    = req_dw ? req_in1 : XLEN'($signed(req_in1[31:0]));
        op_b    = req_dw ? req_in2 : XLEN'($signed(req_in2[31:0]));
        op_a_zx = req_dw ? req_in1 : XLEN'(req_in1[31:0]);
        shamt   = req_dw ? req_in2[SHW-1:0] : SHW'(req_in2[4:0]);
        alu_raw = '0;
        case (req_fn)
            4'd0:    alu_raw = op_a + op_b;
            4'd1:    alu_raw = op_a - op_b;
            4'd2:    alu_raw = op_a << shamt;
            4'd3:    alu_raw = XLEN'($signed(op_a) < $signed(op_b));
            4'd4:    alu_raw = XLEN'(op_a < op_b);
            4'd5:    alu_raw = op_a ^ op_b;
            4'd6:    alu_raw = op_a_zx >> shamt;
            4'd7:    alu_raw = $signed(op_a) >>> shamt;
            4'd8:    alu_raw = op_a | op_b;
            4'd9:    alu_raw = op_a & op_b;
            4'd10:   alu_raw = op_b;
            default: alu_raw = '0;
        endcase
        alu_out = req_dw ? alu_raw : XLEN'($signed(alu_raw[31:0]));
    end

    // Squash evaluation and the global stall/handshake decision; kill drops
    // resp_valid, which in turn lifts any stall so the flush always proceeds.
    always_comb begin
        for (int k = 1; k <= LATENCY; k++) begin
            stg_live[k] = stg_valid[k] & ~kill & ~(|(stg_mask[k] & br_mispredict_mask));
        end
        resp_valid = stg_live[LATENCY];
        stall      = resp_valid & ~resp_ready;
        req_ready  = ~stall;
        req_hit    = |(req_br_mask & br_mispredict_mask);
        req_fire   = req_valid & req_ready & ~kill & ~req_hit;
    end

    // Stage valid bits: hold (minus squashed ops) on stall, otherwise shift forward.
    always_ff @(posedge clock) begin
        if (reset) begin
            stg_valid <= '0;
        end else if (stall) begin
            stg_valid <= stg_live;
        end else begin
            stg_valid[1] <= req_fire;
            for (int k = 2; k <= LATENCY; k++) begin
                stg_valid[k] <= stg_live[k-1];
            end
        end
    end

    // Stage payload: branch masks drop resolved bits every cycle, payload shifts
    // only when the pipe is not stalled. Payload is intentionally not reset.
    always_ff @(posedge clock) begin
        if (stall) begin
            for (int k = 1; k <= LATENCY; k++) begin
                stg_mask[k] <= stg_mask[k] & ~br_resolve_mask;
            end
        end else begin
            stg_mask[1] <= req_br_mask & ~br_resolve_mask;
            stg_data[1] <= alu_out;
            stg_pdst[1] <= req_pdst;
            stg_rob[1]  <= req_rob_idx;
            for (int k = 2; k <= LATENCY; k++) begin
                stg_mask[k] <= stg_mask[k-1] & ~br_resolve_mask;
                stg_data[k] <= stg_data[k-1];
                stg_pdst[k] <= stg_pdst[k-1];
                stg_rob[k]  <= stg_rob[k-1];
            end
        end
    end

    // Response port is the last stage.
    always_comb begin
        resp_data    = stg_data[LATENCY];
        resp_pdst    = stg_pdst[LATENCY];
        resp_rob_idx = stg_rob[LATENCY];
    end

    // Bypass ports: slot 0 is the accepted request with its ALU result, slots
    // 1..LATENCY-1 are the stage registers with squash applied.
    always_comb begin
        bypass_valid = '0;
        bypass_pdst  = '0;
        bypass_data  = '0;
        bypass_valid[0]       = req_fire;
        bypass_pdst[TAG_W-1:0] = req_pdst;
        bypass_data[XLEN-1:0]  = alu_out;
        for (int k = 1; k < LATENCY; k++) begin
            bypass_valid[k]               = stg_live[k];
            bypass_pdst[k*TAG_W +: TAG_W] = stg_pdst[k];
            bypass_data[k*XLEN +: XLEN]   = stg_data[k];
        end
    end

`ifdef ALU_PIPE_PERF_EN
    logic [31:0] killed_now;

    // Number of valid ops squashed this cycle, stages plus the incoming request.
    always_comb begin
        killed_now = '0;
        for (int k = 1; k <= LATENCY; k++) begin
            if (stg_valid[k] && !stg_live[k]) begin
                killed_now = killed_now + 32'd1;
            end
        end
        if (req_valid && req_ready && (kill || req_hit)) begin
            killed_now = killed_now + 32'd1;
        end
    end

    // Wrapping performance counters.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_done   <= '0;
            perf_killed <= '0;
            perf_stall  <= '0;
        end else begin
            perf_done   <= perf_done + 32'(resp_valid & resp_ready);
            perf_killed <= perf_killed + killed_now;
            perf_stall  <= perf_stall + 32'(stall);
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe_unit.sv
// tb_alu_pipe_unit: drives alu_pipe_unit with directed scenarios and random
// traffic and compares every cycle against a queue-based behavioural model.

module tb_alu_pipe_unit;

    localparam int XLEN  = 64;
    localparam int BR_W  = 20;
    localparam int TAG_W = 7;
    localparam int L     = 3;

    logic                 clock;
    logic                 reset;
    logic                 req_valid;
    logic                 req_ready;
    logic [3:0]           req_fn;
    logic                 req_dw;
    logic [XLEN-1:0]      req_in1;
    logic [XLEN-1:0]      req_in2;
    logic [TAG_W-1:0]     req_pdst;
    logic [TAG_W-1:0]     req_rob_idx;
    logic [BR_W-1:0]      req_br_mask;
    logic                 kill;
    logic [BR_W-1:0]      br_resolve_mask;
    logic [BR_W-1:0]      br_mispredict_mask;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [XLEN-1:0]      resp_data;
    logic [TAG_W-1:0]     resp_pdst;
    logic [TAG_W-1:0]     resp_rob_idx;
    logic [L-1:0]         bypass_valid;
    logic [L*TAG_W-1:0]   bypass_pdst;
    logic [L*XLEN-1:0]    bypass_data;

    alu_pipe_unit #(
        .XLEN(XLEN), .BR_W(BR_W), .TAG_W(TAG_W), .LATENCY(L)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_fn(req_fn), .req_dw(req_dw),
        .req_in1(req_in1), .req_in2(req_in2), .req_pdst(req_pdst),
        .req_rob_idx(req_rob_idx), .req_br_mask(req_br_mask), .kill(kill),
        .br_resolve_mask(br_resolve_mask), .br_mispredict_mask(br_mispredict_mask),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_pdst(resp_pdst), .resp_rob_idx(resp_rob_idx),
        .bypass_valid(bypass_valid), .bypass_pdst(bypass_pdst), .bypass_data(bypass_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_chk = 0;
    int n_err = 0;

    // In-flight op as the model sees it: pos = number of cycles it has advanced.
    typedef struct {
        int               pos;
        logic [BR_W-1:0]  mask;
        logic [63:0]      data;
        logic [TAG_W-1:0] pdst;
        logic [TAG_W-1:0] rob;
    } op_t;
    op_t inflight[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU straight from the function table.
    function automatic logic [63:0] ref_alu(input logic [3:0] fn, input logic dw,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] sx, sy;
        logic [31:0]        x, y, r32;
        logic [63:0]        r;
        int                 sh;
        r = '0;
        if (dw) begin
            sa = a; sb = b; sh = int'(b[5:0]);
            case (fn)
                4'd0:  r = a + b;
                4'd1:  r = a - b;
                4'd2:  r = a << sh;
                4'd3:  r = (sa < sb) ? 64'd1 : 64'd0;
                4'd4:  r = (a < b) ? 64'd1 : 64'd0;
                4'd5:  r = a ^ b;
                4'd6:  r = a >> sh;
                4'd7:  r = sa >>> sh;
                4'd8:  r = a | b;
                4'd9:  r = a & b;
                4'd10: r = b;
                default: r = '0;
            endcase
        end else begin
            x = a[31:0]; y = b[31:0]; sx = x; sy = y; sh = int'(b[4:0]);
            case (fn)
                4'd0:  r32 = x + y;
                4'd1:  r32 = x - y;
                4'd2:  r32 = x << sh;
                4'd3:  r32 = (sx < sy) ? 32'd1 : 32'd0;
                4'd4:  r32 = ({{32{x[31]}}, x} < {{32{y[31]}}, y}) ? 32'd1 : 32'd0;
                4'd5:  r32 = x ^ y;
                4'd6:  r32 = x >> sh;
                4'd7:  r32 = sx >>> sh;
                4'd8:  r32 = x | y;
                4'd9:  r32 = x & y;
                4'd10: r32 = y;
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction

    task automatic apply_stimulus(input logic v, input logic [3:0] fn, input logic dw,
                                  input logic [63:0] a, input logic [63:0] b,
                                  input logic [TAG_W-1:0] pd, input logic [TAG_W-1:0] rob,
                                  input logic [BR_W-1:0] mask, input logic kl,
                                  input logic [BR_W-1:0] res, input logic [BR_W-1:0] mis,
                                  input logic rdy);
        @(negedge clock);
        req_valid = v; req_fn = fn; req_dw = dw; req_in1 = a; req_in2 = b;
        req_pdst = pd; req_rob_idx = rob; req_br_mask = mask; kill = kl;
        br_resolve_mask = res; br_mispredict_mask = mis; resp_ready = rdy;
    endtask

    // Compare all outputs against the model for this cycle, then advance the model
    // to what must hold after the coming clock edge.
    task automatic check_output();
        logic             ev [0:L-1];
        logic [63:0]      ed [0:L-1];
        logic [TAG_W-1:0] ep [0:L-1];
        logic             erv;
        logic [63:0]      erd;
        logic [TAG_W-1:0] erp, err;
        logic             estall;
        op_t              nq[$];
        op_t              o;
        #1;
        for (int k = 0; k < L; k++) begin ev[k] = 1'b0; ed[k] = '0; ep[k] = '0; end
        erv = 1'b0; erd = '0; erp = '0; err = '0;
        foreach (inflight[i]) begin
            if (!(kill || (|(inflight[i].mask & br_mispredict_mask)))) begin
                if (inflight[i].pos == L) begin
                    erv = 1'b1; erd = inflight[i].data;
                    erp = inflight[i].pdst; err = inflight[i].rob;
                end else begin
                    ev[inflight[i].pos] = 1'b1;
                    ed[inflight[i].pos] = inflight[i].data;
                    ep[inflight[i].pos] = inflight[i].pdst;
                end
            end
        end
        estall = erv && !resp_ready;
        ev[0] = req_valid && !estall && !kill && !(|(req_br_mask & br_mispredict_mask));
        ed[0] = ref_alu(req_fn, req_dw, req_in1, req_in2);
        ep[0] = req_pdst;

        chk("resp_valid", 64'(resp_valid), 64'(erv));
        chk("req_ready", 64'(req_ready), 64'(!estall));
        if (erv) begin
            chk("resp_data", resp_data, erd);
            chk("resp_pdst", 64'(resp_pdst), 64'(erp));
            chk("resp_rob_idx", 64'(resp_rob_idx), 64'(err));
        end
        for (int k = 0; k < L; k++) begin
            chk($sformatf("bypass_valid[%0d]", k), 64'(bypass_valid[k]), 64'(ev[k]));
            if (ev[k]) begin
                chk($sformatf("bypass_data[%0d]", k), bypass_data[k*XLEN +: XLEN], ed[k]);
                chk($sformatf("bypass_pdst[%0d]", k), 64'(bypass_pdst[k*TAG_W +: TAG_W]), 64'(ep[k]));
            end
        end

        foreach (inflight[i]) begin
            o = inflight[i];
            if (kill || (|(o.mask & br_mispredict_mask))) continue;
            o.mask = o.mask & ~br_resolve_mask;
            if (!estall) begin
                if (o.pos == L) continue;
                o.pos++;
            end
            nq.push_back(o);
        end
        if (ev[0]) begin
            o.pos = 1; o.mask = req_br_mask & ~br_resolve_mask;
            o.data = ed[0]; o.pdst = req_pdst; o.rob = req_rob_idx;
            nq.push_back(o);
        end
        inflight = nq;
    endtask

    task automatic idle(input logic rdy);
        apply_stimulus(1'b0, 4'd0, 1'b1, '0, '0, '0, '0, '0, 1'b0, '0, '0, rdy);
        check_output();
    endtask

    task automatic drain();
        for (int i = 0; i < L + 2; i++) idle(1'b1);
    endtask

    function automatic logic [63:0] rand_operand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'h0000_0000_7FFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'($urandom_range(0, 70));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [BR_W-1:0] rand_bit(input int one_in);
        if ($urandom_range(1, one_in) != 1) return '0;
        return BR_W'(1) << $urandom_range(0, 3);
    endfunction

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_fn = '0; req_dw = 1'b0; req_in1 = '0; req_in2 = '0;
        req_pdst = '0; req_rob_idx = '0; req_br_mask = '0; kill = 1'b0;
        br_resolve_mask = '0; br_mispredict_mask = '0; resp_ready = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        chk("reset resp_valid", 64'(resp_valid), 64'd0);
        chk("reset bypass_valid", 64'(bypass_valid), 64'd0);
        chk("reset req_ready", 64'(req_ready), 64'd1);

        // ADD 5+7: bypass 0 same cycle, resp three cycles later
        apply_stimulus(1'b1, 4'd0, 1'b1, 64'd5, 64'd7, 7'd3, 7'd11, '0, 1'b0, '0, '0, 1'b1);
        check_output();
        chk("add bypass0 valid", 64'(bypass_valid[0]), 64'd1);
        chk("add bypass0 data", bypass_data[XLEN-1:0], 64'd12);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("add resp_valid c3", 64'(resp_valid), 64'd1);
        chk("add resp_data c3", resp_data, 64'd12);
        drain();

        // 32-bit overflow sign-extension and 64-bit arithmetic shift
        apply_stimulus(1'b1, 4'd0, 1'b0, 64'h7FFF_FFFF, 64'd1, 7'd1, 7'd1, '0, 1'b0, '0, '0, 1'b1);
        check_output();
        chk("addw sext", bypass_data[XLEN-1:0], 64'hFFFF_FFFF_8000_0000);
        apply_stimulus(1'b1, 4'd7, 1'b1, 64'h8000_0000_0000_0000, 64'd4, 7'd2, 7'd2, '0, 1'b0, '0, '0, 1'b1);
        check_output();
        chk("sra 64", bypass_data[XLEN-1:0], 64'hF800_0000_0000_0000);
        drain();

        // A,B,C back to back, 2-cycle stall when A reaches resp
        apply_stimulus(1'b1, 4'd8, 1'b1, 64'hA0, 64'h0A, 7'd10, 7'd20, '0, 1'b0, '0, '0, 1'b1);
        check_output();
        apply_stimulus(1'b1, 4'd5, 1'b1, 64'hB0, 64'h0B, 7'd11, 7'd21, '0, 1'b0, '0, '0, 1'b1);
        check_output();
        apply_stimulus(1'b1, 4'd1, 1'b1, 64'hC0, 64'h0C, 7'd12, 7'd22, '0, 1'b0, '0, '0, 1'b1);
        check_output();
        idle(1'b0);
        chk("stall A held c3", 64'(resp_rob_idx), 64'd20);
        chk("stall req_ready", 64'(req_ready), 64'd0);
        idle(1'b0);
        chk("stall A held c4", 64'(resp_rob_idx), 64'd20);
        idle(1'b1);
        chk("stall A out", 64'(resp_rob_idx), 64'd20);
        idle(1'b1);
        chk("stall B out", 64'(resp_rob_idx), 64'd21);
        idle(1'b1);
        chk("stall C out", 64'(resp_rob_idx), 64'd22);
        chk("stall C data", resp_data, 64'hB4);
        drain();

        // resolve and mispredict of the same bit in stage 2: killed
        apply_stimulus(1'b1, 4'd0, 1'b1, 64'd1, 64'd2, 7'd5, 7'd40, 20'h00004, 1'b0, '0, '0, 1'b1);
        check_output();
        idle(1'b1);
        apply_stimulus(1'b0, 4'd0, 1'b1, '0, '0, '0, '0, '0, 1'b0, 20'h00004, 20'h00004, 1'b1);
        check_output();
        chk("res+mis bypass2", 64'(bypass_valid[2]), 64'd0);
        idle(1'b1);
        chk("res+mis no resp", 64'(resp_valid), 64'd0);
        drain();

        // resolved first, mispredicted next cycle: survives
        apply_stimulus(1'b1, 4'd10, 1'b1, 64'd0, 64'h1234, 7'd6, 7'd41, 20'h00010, 1'b0, '0, '0, 1'b1);
        check_output();
        apply_stimulus(1'b0, 4'd0, 1'b1, '0, '0, '0, '0, '0, 1'b0, 20'h00010, '0, 1'b1);
        check_output();
        apply_stimulus(1'b0, 4'd0, 1'b1, '0, '0, '0, '0, '0, 1'b0, '0, 20'h00010, 1'b1);
        check_output();
        idle(1'b1);
        chk("resolved survives", 64'(resp_valid), 64'd1);
        chk("resolved data", resp_data, 64'h1234);
        drain();

        // kill while stalled with three ops in flight
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 4'd0, 1'b1, 64'(i), 64'd1, 7'(30 + i), 7'(50 + i), '0, 1'b0, '0, '0, 1'b1);
            check_output();
        end
        idle(1'b0);
        chk("kill pre stall", 64'(req_ready), 64'd0);
        apply_stimulus(1'b0, 4'd0, 1'b1, '0, '0, '0, '0, '0, 1'b1, '0, '0, 1'b0);
        check_output();
        idle(1'b0);
        chk("kill resp_valid", 64'(resp_valid), 64'd0);
        chk("kill bypass_valid", 64'(bypass_valid), 64'd0);
        chk("kill req_ready", 64'(req_ready), 64'd1);
        drain();

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            apply_stimulus($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), 1'($urandom),
                           rand_operand(), rand_operand(), 7'($urandom), 7'($urandom),
                           rand_bit(2), $urandom_range(0, 49) == 0,
                           rand_bit(6), rand_bit(12), $urandom_range(0, 3) != 0);
            check_output();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/alu_pipe_unit.md
Name: alu_pipe_unit

Overview:
- Parametrised integer execute unit: a single-cycle ALU followed by a LATENCY-deep result pipeline.
- Each in-flight op carries a branch mask and is squashed by mispredict or global kill.
- Per-stage bypass ports are masked by kill.
- Adds output backpressure (resp_ready): the whole pipe stalls as one unit.
- Sits in the integer issue path, between regfile read and writeback arbitration.

Parameters:
XLEN, 64, datapath width (32 or 64)
BR_W, 20, branch mask width
TAG_W, 7, pdst / rob_idx width
LATENCY, 3, pipeline stages from accept to resp (1..4)

Ports:
clock  in  1  clock
reset  in  1  reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_fn  in  4  ALU function
req_dw  in  1  1 = XLEN-wide op, 0 = 32-bit op
req_in1  in  XLEN  operand 1
req_in2  in  XLEN  operand 2
req_pdst  in  TAG_W  destination physical register
req_rob_idx  in  TAG_W  ROB index
req_br_mask  in  BR_W  branches this op depends on
kill  in  1  flush every in-flight op and the incoming request
br_resolve_mask  in  BR_W  branches resolved this cycle
br_mispredict_mask  in  BR_W  branches mispredicted this cycle
resp_valid  out  1  result valid at the last stage
resp_ready  in  1  consumer accepts result
resp_data  out  XLEN  result
resp_pdst  out  TAG_W  result pdst
resp_rob_idx  out  TAG_W  result ROB index
bypass_valid  out  LATENCY  per-stage bypass valid, index k = stage k
bypass_pdst  out  LATENCY*TAG_W  per-stage pdst
bypass_data  out  LATENCY*XLEN  per-stage data

Behaviour:
- Reset: synchronous, active-high. All stage valids clear, so resp_valid=0 and bypass_valid=0 at reset. Data and metadata registers are not reset.
- ALU encoding (req_fn): 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS (result = in2). Codes 11-15 produce 0.
- dw=0:
  - Operands are the low 32 bits; shift amount is in2[4:0].
  - SRL/SRA operate on in1[31:0].
  - Result is sign-extended from bit 31.
  - SLT/SLTU compare sign-extended low words.
- dw=1: shift amount is in2[log2(XLEN)-1:0].
- Stages: stage 0 is combinational (request + ALU output); stages 1..LATENCY are registers.
  - Accepted op appears on resp exactly LATENCY cycles after acceptance if no stall occurs.
- Stall: stall = resp_valid & ~resp_ready.
  - While stalled, every stage holds its contents and req_ready=0.
  - req_ready = ~stall, independent of req_valid (no ready-on-valid dependency).
  - Bubbles do not collapse: a stall freezes the whole pipe.
- Branch masks, applied every cycle including stalled cycles:
  - Each stage's mask is updated to mask & ~br_resolve_mask.
  - A stage (or incoming request) with (mask & br_mispredict_mask) != 0 has its valid cleared.
  - Same bit resolved and mispredicted in one cycle: mispredict wins, op killed.
- kill: clears every stage valid and blocks the incoming request that cycle. Takes priority over stall and resolve.
  - Killing the resp stage while stalled clears resp_valid next cycle; the pipe resumes.
- Bypass:
  - bypass_valid[0] = req_valid & req_ready & ~kill & no mispredict hit; data is the ALU output.
  - bypass k≥1 = stage k register, valid masked by that cycle's kill/mispredict.
  - No bypass output for stage LATENCY (that is resp).
- resp_valid = stage LATENCY valid & ~kill & no mispredict hit this cycle.
- Handshake completes when resp_valid & resp_ready.

Optional Feature:
ALU_PIPE_PERF_EN:
- Defined: adds three outputs, each a 32-bit wrapping counter cleared by reset:
  - perf_done: increments on each resp handshake.
  - perf_killed: increments per valid op squashed by kill/mispredict, summed across stages; max LATENCY+1 per cycle.
  - perf_stall: increments on each stall cycle.
- Undefined: these ports and counters do not exist.

Test Plan:
- LATENCY=3, resp_ready=1: ADD in1=5, in2=7 accepted at cycle 0. Required: bypass_data[0]=12 in cycle 0; resp_valid=1 with resp_data=12 in cycle 3.
- dw=0 ADD in1=0x7FFFFFFF, in2=1 -> resp_data=0xFFFFFFFF80000000. SRA dw=1 in1=0x8000000000000000, in2=4 -> 0xF800000000000000.
- Back-to-back ops A,B,C with resp_ready=0 for 2 cycles when A reaches resp. Required: A held for the stall, req_ready=0, no op lost or duplicated; A,B,C emerge in order.
- Op in stage 2 with br_mask=0x00004, br_resolve_mask=0x00004 in the same cycle as br_mispredict_mask=0x00004. Required: op killed, bypass_valid[2]=0 that cycle, no resp.
- Op with br_mask=0x00010 resolved (resolve=0x00010), then mispredict=0x00010 next cycle. Required: op survives and completes.
- kill asserted while resp stalled with 3 ops in flight. Required: next cycle resp_valid=0, all bypass_valid=0, req_ready=1; with ALU_PIPE_PERF_EN, perf_killed += 3.
